nibble_mayor_ctrl: RTL and testbench

//  Sequencer that finds the largest nibble over a variable-length frame of words.

---
 rtl/nibble_mayor_ctrl_pkg.sv | 19 +
 rtl/nibble_mayor_ctrl_scan_dp.sv | 82 ++++++++
 rtl/nibble_mayor_ctrl.sv | 109 ++++++++++
 tb/tb_nibble_mayor_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_mayor_ctrl_pkg.sv
// Shared state encoding, nibble width and comparison helper for the
// frame-level largest-nibble sequencer.
package nibble_mayor_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Strict comparison: equal nibbles never displace the earlier maximum.
    function automatic logic nib_gt(input logic [NIB_W-1:0] a,
                                    input logic [NIB_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/nibble_mayor_ctrl_scan_dp.sv
// Datapath for the nibble sequencer: captured word, nibble mux, strict
// comparator and the running max / first-index / frame-position registers.
module nibble_scan_dp
    import nibble_mayor_ctrl_pkg::*;
#(
    parameter int NUM_NIBBLES = 4,
    parameter int IDX_W       = 8,
    parameter int CNT_W       = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cap_i,
    input  logic [NUM_NIBBLES*NIB_W-1:0] data_i,
    input  logic                         scan_i,
    input  logic [CNT_W-1:0]             cnt_i,
    input  logic                         clr_i,
    output logic [NIB_W-1:0]             max_nxt_o,
    output logic [IDX_W-1:0]             idx_nxt_o
);

    localparam int WORD_W = NUM_NIBBLES * NIB_W;

    logic [WORD_W-1:0] word_q, word_d;
    logic [NIB_W-1:0]  max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  pos_q, pos_d;
    logic [NIB_W-1:0]  nib_sel;

    // Position sticks at all-ones once a frame outgrows the counter.
    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (&v) ? v : v + IDX_W'(1);
    endfunction

    always_comb begin
        nib_sel = '0;
        for (int k = 0; k < NUM_NIBBLES; k++) begin
            if (cnt_i == CNT_W'(k)) begin
                nib_sel = word_q[k*NIB_W +: NIB_W];
            end
        end
    end

    always_comb begin
        word_d = word_q;
        max_d  = max_q;
        idx_d  = idx_q;
        pos_d  = pos_q;
        if (cap_i) begin
            word_d = data_i;
        end
        if (clr_i) begin
            max_d = '0;
            idx_d = '0;
            pos_d = '0;
        end else if (scan_i) begin
            if (nib_gt(nib_sel, max_q)) begin
                max_d = nib_sel;
                idx_d = pos_q;
            end
            pos_d = sat_inc(pos_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            max_q  <= '0;
            idx_q  <= '0;
            pos_q  <= '0;
        end else begin
            word_q <= word_d;
            max_q  <= max_d;
            idx_q  <= idx_d;
            pos_q  <= pos_d;
        end
    end

    // The final scan step is folded in here so the top can latch the result on the same edge.
    assign max_nxt_o = max_d;
    assign idx_nxt_o = idx_d;

endmodule

// File: rtl/nibble_mayor_ctrl.sv
// Frame-level largest-nibble sequencer: FSM, nibble counter and stream
// handshakes around a single time-shared nibble comparator.
module nibble_mayor_ctrl
    import nibble_mayor_ctrl_pkg::*;
#(
    parameter int NUM_NIBBLES = 4,
    parameter int IDX_W       = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [4*NUM_NIBBLES-1:0] IN_DATA,
    input  logic                     IN_LAST,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [3:0]               OUT_NIBBLE,
    output logic [IDX_W-1:0]         OUT_INDEX
);

    localparam int CNT_W = $clog2(NUM_NIBBLES);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q;
    logic               out_valid_q;
    logic [NIB_W-1:0]   out_nib_q;
    logic [IDX_W-1:0]   out_idx_q;

    logic               accept;
    logic               scan_en;
    logic               scan_end;
    logic               clr;
    logic [NIB_W-1:0]   max_nxt;
    logic [IDX_W-1:0]   idx_nxt;

    assign IN_READY = (state_q == ST_IDLE) & ~RESET;
    assign accept   = IN_VALID & IN_READY;
    assign scan_en  = (state_q == ST_SCAN);
    assign scan_end = scan_en && (cnt_q == CNT_W'(NUM_NIBBLES - 1));
    assign clr      = (state_q == ST_DONE) & OUT_READY;

    nibble_scan_dp #(
        .NUM_NIBBLES (NUM_NIBBLES),
        .IDX_W       (IDX_W),
        .CNT_W       (CNT_W)
    ) u_dp (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .cap_i     (accept),
        .data_i    (IN_DATA),
        .scan_i    (scan_en),
        .cnt_i     (cnt_q),
        .clr_i     (clr),
        .max_nxt_o (max_nxt),
        .idx_nxt_o (idx_nxt)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_nib_q   <= '0;
            out_idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        last_q  <= IN_LAST;
                        cnt_q   <= '0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (scan_end) begin
                        cnt_q <= '0;
                        // A non-final word returns to IDLE with max/idx/pos kept in the datapath.
                        if (last_q) begin
                            out_nib_q   <= max_nxt;
                            out_idx_q   <= idx_nxt;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign OUT_VALID  = out_valid_q;
    assign OUT_NIBBLE = out_nib_q;
    assign OUT_INDEX  = out_idx_q;

endmodule

// File: tb/tb_nibble_mayor_ctrl.sv
// Directed and randomized bench for nibble_mayor_ctrl with a result scoreboard.
module tb_nibble_mayor_ctrl;

    localparam int NN = 4;
    localparam int IW = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          IN_VALID;
    logic          IN_READY;
    logic [4*NN-1:0] IN_DATA;
    logic          IN_LAST;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [3:0]    OUT_NIBBLE;
    logic [IW-1:0] OUT_INDEX;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]    nib;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] frame_q[$];

    always #5 CLK = ~CLK;

    nibble_mayor_ctrl #(.NUM_NIBBLES(NN), .IDX_W(IW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_DATA    (IN_DATA),
        .IN_LAST    (IN_LAST),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_NIBBLE (OUT_NIBBLE),
        .OUT_INDEX  (OUT_INDEX)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] nib, input logic [IW-1:0] idx);
        exp_t e;
        e.nib = nib;
        e.idx = idx;
        sb_q.push_back(e);
    endtask

    // Returns at 1 time unit after the accepting edge.
    task automatic send_word(input logic [15:0] d, input logic l, input int gap);
        bit acc;
        acc = 1'b0;
        repeat (gap) @(posedge CLK);
        #1;
        IN_DATA  = d;
        IN_LAST  = l;
        IN_VALID = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge CLK);
            if (IN_READY) acc = 1'b1;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        IN_DATA  = $urandom;
        check("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic expect_result(input bit rand_ready);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            OUT_READY = rand_ready ? ($urandom_range(0, 3) == 0) : 1'b1;
            @(negedge CLK);
            if (OUT_VALID && OUT_READY) begin
                got = 1'b1;
                check("sb_depth", sb_q.size(), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("out_nibble", {28'd0, OUT_NIBBLE}, {28'd0, e.nib});
                    check("out_index", {24'd0, OUT_INDEX}, {24'd0, e.idx});
                end
            end
            @(posedge CLK);
            #1;
        end
        OUT_READY = 1'b0;
        check("result_timeout", {31'd0, got}, 32'd1);
    endtask

    // Expected result counts nibbles across the frame; positions beyond 255 read 255.
    task automatic send_frame(input int gap_max);
        logic [3:0]  mx;
        logic [3:0]  n;
        logic [15:0] w;
        int          ix;
        int          cnt;
        mx  = 4'd0;
        ix  = 0;
        cnt = 0;
        for (int j = 0; j < frame_q.size(); j++) begin
            w = frame_q[j];
            for (int k = 0; k < NN; k++) begin
                n = w[4*k +: 4];
                if (n > mx) begin
                    mx = n;
                    ix = (cnt > 255) ? 255 : cnt;
                end
                cnt++;
            end
        end
        push_exp(mx, IW'(ix));
        for (int j = 0; j < frame_q.size(); j++) begin
            send_word(frame_q[j], (j == frame_q.size() - 1), $urandom_range(0, gap_max));
        end
    endtask

    initial begin
        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        IN_DATA   = '0;
        IN_LAST   = 1'b0;
        OUT_READY = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_out_nibble", {28'd0, OUT_NIBBLE}, 32'd0);
        check("rst_out_index", {24'd0, OUT_INDEX}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("idle_in_ready", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK);
        #1;

        // Single word: nibbles 1,7,A,3 -> A at position 2, valid after 4 edges.
        push_exp(4'hA, 8'd2);
        send_word(16'h3A71, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("t1_busy_ready", {31'd0, IN_READY}, 32'd0);
            check("t1_busy_valid", {31'd0, OUT_VALID}, 32'd0);
        end
        @(negedge CLK);
        check("t1_valid_rise", {31'd0, OUT_VALID}, 32'd1);
        @(posedge CLK);
        #1;
        expect_result(1'b0);

        // Tie: first 9 at position 1 wins.
        push_exp(4'h9, 8'd1);
        send_word(16'h9191, 1'b1, 0);
        expect_result(1'b0);

        // Two-word frame, F at position 6.
        push_exp(4'hF, 8'd6);
        send_word(16'h1111, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("t3_busy_ready0", {31'd0, IN_READY}, 32'd0);
        end
        @(negedge CLK);
        check("t3_ready_back", {31'd0, IN_READY}, 32'd1);
        check("t3_no_valid", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        send_word(16'h2F00, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("t3_busy_ready1", {31'd0, IN_READY}, 32'd0);
        end
        @(posedge CLK);
        #1;
        expect_result(1'b0);

        // Reset during the second scan cycle abandons the frame.
        send_word(16'h0C0D, 1'b1, 0);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, OUT_VALID}, 32'd0);
        check("t5_rst_nibble", {28'd0, OUT_NIBBLE}, 32'd0);
        check("t5_rst_index", {24'd0, OUT_INDEX}, 32'd0);
        check("t5_rst_ready", {31'd0, IN_READY}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("t5_post_ready", {31'd0, IN_READY}, 32'd1);
        check("t5_post_valid", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        push_exp(4'h5, 8'd0);
        send_word(16'h0005, 1'b1, 0);
        expect_result(1'b0);

        // Backpressure: nibbles 7,2,B,5 -> B at 2, held for 10 cycles.
        push_exp(4'hB, 8'd2);
        send_word(16'h5B27, 1'b1, 0);
        repeat (4) @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("t4_hold_valid", {31'd0, OUT_VALID}, 32'd1);
            check("t4_hold_nibble", {28'd0, OUT_NIBBLE}, 32'hB);
            check("t4_hold_index", {24'd0, OUT_INDEX}, 32'd2);
            check("t4_hold_ready", {31'd0, IN_READY}, 32'd0);
        end
        @(posedge CLK);
        #1;
        expect_result(1'b0);
        @(negedge CLK);
        check("t4_idle_ready", {31'd0, IN_READY}, 32'd1);
        check("t4_idle_valid", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        push_exp(4'h0, 8'd0);
        send_word(16'h0000, 1'b1, 0);
        expect_result(1'b0);

        // Frame longer than 256 nibbles: the late 3 reports the saturated index.
        frame_q.delete();
        for (int i = 0; i < 64; i++) frame_q.push_back(16'h1111);
        frame_q.push_back(16'h0030);
        send_frame(0);
        expect_result(1'b0);

        // Random frames with input gaps and random output backpressure.
        for (int f = 0; f < 20; f++) begin
            frame_q.delete();
            for (int i = 0; i < $urandom_range(1, 8); i++) begin
                frame_q.push_back(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
            end
            send_frame(3);
            expect_result(1'b1);
        end

        check("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
